// File: rtl/exec_pkg.sv
// exec_pkg: shared encodings and constants for the execute stage
package exec_pkg;
  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_SLL  = 5'b00001,
    ALU_SLT  = 5'b00010,
    ALU_SLTU = 5'b00011,
    ALU_XOR  = 5'b00100,
    ALU_SRL  = 5'b00101,
    ALU_OR   = 5'b00110,
    ALU_AND  = 5'b00111,
    ALU_SUB  = 5'b01000,
    ALU_SRA  = 5'b01101,
    ALU_BEQ  = 5'b10000,
    ALU_BNE  = 5'b10001,
    ALU_BLT  = 5'b10100,
    ALU_BGE  = 5'b10101,
    ALU_BLTU = 5'b10110,
    ALU_BGEU = 5'b10111
  } alu_op_e;
  typedef enum logic [2:0] {
    CSR_RW     = 3'b001,
    CSR_RS     = 3'b010,
    CSR_RC     = 3'b011,
    CSR_ECALL  = 3'b100,
    CSR_EBREAK = 3'b101,
    CSR_MRET   = 3'b110
  } csr_op_e;
  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
  localparam logic [31:0] MISA_VAL      = 32'h4000_0100;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
endpackage

// File: rtl/reg_adder32.sv
// reg_adder32: 32-bit adder whose sum is captured only when enabled
module reg_adder32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  // capture the wrapped sum on enabled edges, hold otherwise
  always_ff @(posedge clk or negedge reset)
    if (!reset) sum <= '0;
    else if (en) sum <= a + b;
endmodule

// File: rtl/execute_unit.sv
// execute_unit: registered PC adders, integer ALU and machine-mode CSR file
module execute_unit
  import exec_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        npc_en,
  input  logic        off_en,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [5:0]  alu_mc,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [15:0] csr_mc,
  input  logic [31:0] csr_in,
  output logic [31:0] next_pc,
  output logic [31:0] offset_pc,
  output logic [31:0] alu_out,
  output logic [31:0] csr_out,
  output logic [31:0] ex_out,
  output logic        fault
);
  logic        alu_fault, csr_fault, alu_ok;
  logic [31:0] alu_res;
  logic [31:0] mstatus, mtvec, mscratch, mepc, mcause;
  logic [31:0] csr_rd, csr_res, csr_wdata;
  logic        csr_def, csr_ro, csr_rw_op, csr_wr, csr_trap, csr_err;
  logic [11:0] addr;
  logic [2:0]  op;
  reg_adder32 u_npc (.clk(clk), .reset(reset), .en(npc_en), .a(pc), .b(32'd4), .sum(next_pc));
  reg_adder32 u_off (.clk(clk), .reset(reset), .en(off_en), .a(pc), .b(imm), .sum(offset_pc));
  assign ex_out = alu_mc[5] ? alu_out : csr_out;
  assign fault  = alu_fault | csr_fault;
  assign addr   = csr_mc[14:3];
  assign op     = csr_mc[2:0];
  // ALU result and op legality; illegal ops keep the previous result
  always_comb begin
    alu_res = alu_out;
    alu_ok  = 1'b1;
    case (alu_mc[4:0])
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_SLL:  alu_res = alu_a << alu_b[4:0];
      ALU_SLT:  alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_res = {31'b0, alu_a < alu_b};
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_SRL:  alu_res = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_res = $signed(alu_a) >>> alu_b[4:0];
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_AND:  alu_res = alu_a & alu_b;
      ALU_BEQ:  alu_res = {31'b0, alu_a == alu_b};
      ALU_BNE:  alu_res = {31'b0, alu_a != alu_b};
      ALU_BLT:  alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_BGE:  alu_res = {31'b0, $signed(alu_a) >= $signed(alu_b)};
      ALU_BLTU: alu_res = {31'b0, alu_a < alu_b};
      ALU_BGEU: alu_res = {31'b0, alu_a >= alu_b};
      default:  alu_ok  = 1'b0;
    endcase
  end
  // ALU result register; a fault leaves the result untouched
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      alu_out   <= '0;
      alu_fault <= 1'b0;
    end else if (alu_mc[5]) begin
      alu_fault <= !alu_ok;
      if (alu_ok) alu_out <= alu_res;
    end
  // CSR address decode, with the low bits of mtvec/mepc reading as zero
  always_comb begin
    csr_rd  = '0;
    csr_def = 1'b1;
    csr_ro  = 1'b0;
    case (addr)
      ADDR_MSTATUS:  csr_rd = mstatus;
      ADDR_MTVEC:    csr_rd = {mtvec[31:2], 2'b0};
      ADDR_MSCRATCH: csr_rd = mscratch;
      ADDR_MEPC:     csr_rd = {mepc[31:2], 2'b0};
      ADDR_MCAUSE:   csr_rd = mcause;
      ADDR_MISA:     begin csr_rd = MISA_VAL; csr_ro = 1'b1; end
      ADDR_MHARTID:  csr_ro = 1'b1;
      default:       csr_def = 1'b0;
    endcase
  end
  // CSR op decode: set/clear with a zero operand is a pure read
  always_comb begin
    csr_rw_op = op == CSR_RW || op == CSR_RS || op == CSR_RC;
    csr_trap  = op == CSR_ECALL || op == CSR_EBREAK;
    csr_wr    = csr_rw_op && (op == CSR_RW || csr_in != '0);
    csr_err   = csr_rw_op ? (!csr_def || (csr_wr && csr_ro)) : !(csr_trap || op == CSR_MRET);
    csr_wdata = op == CSR_RW ? csr_in : op == CSR_RS ? csr_rd | csr_in : csr_rd & ~csr_in;
    csr_res   = csr_rw_op ? csr_rd : op == CSR_MRET ? {mepc[31:2], 2'b0} : {mtvec[31:2], 2'b0};
  end
  // CSR state and read-value register; faults change nothing but the flag
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      csr_out   <= '0;
      csr_fault <= 1'b0;
      mstatus   <= '0;
      mtvec     <= '0;
      mscratch  <= '0;
      mepc      <= '0;
      mcause    <= '0;
    end else if (csr_mc[15]) begin
      csr_fault <= csr_err;
      if (!csr_err) begin
        csr_out <= csr_res;
        if (csr_wr)
          case (addr)
            ADDR_MSTATUS:  mstatus  <= csr_wdata;
            ADDR_MTVEC:    mtvec    <= {csr_wdata[31:2], 2'b0};
            ADDR_MSCRATCH: mscratch <= csr_wdata;
            ADDR_MEPC:     mepc     <= {csr_wdata[31:2], 2'b0};
            ADDR_MCAUSE:   mcause   <= csr_wdata;
            default:       ;
          endcase
        if (csr_trap) begin
          mepc   <= {csr_in[31:2], 2'b0};
          mcause <= op == CSR_EBREAK ? CAUSE_EBREAK : CAUSE_ECALL;
        end
      end
    end
endmodule

// File: tb/tb_execute_unit.sv
// tb_execute_unit: directed stimulus with a queued scoreboard and independent monitor
module tb_execute_unit;
  import exec_pkg::*;
  logic        clk = 0, reset = 0, npc_en = 0, off_en = 0;
  logic [31:0] pc = 0, imm = 0, alu_a = 0, alu_b = 0, csr_in = 0;
  logic [5:0]  alu_mc = 0;
  logic [15:0] csr_mc = 0;
  logic [31:0] next_pc, offset_pc, alu_out, csr_out, ex_out;
  logic        fault;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int cyc; int sel; logic [31:0] val; string name;} exp_t;
  exp_t q[$];

  execute_unit dut (.clk(clk), .reset(reset), .npc_en(npc_en), .off_en(off_en), .pc(pc), .imm(imm),
    .alu_mc(alu_mc), .alu_a(alu_a), .alu_b(alu_b), .csr_mc(csr_mc), .csr_in(csr_in),
    .next_pc(next_pc), .offset_pc(offset_pc), .alu_out(alu_out), .csr_out(csr_out),
    .ex_out(ex_out), .fault(fault));

  always #5 clk = ~clk;

  function automatic logic [31:0] pick(int sel);
    case (sel)
      0: return next_pc;
      1: return offset_pc;
      2: return alu_out;
      3: return csr_out;
      4: return {31'b0, fault};
      default: return ex_out;
    endcase
  endfunction

  task automatic compare(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic expect_out(int sel, logic [31:0] val, string name);
    exp_t e;
    e.cyc = cyc + 1; e.sel = sel; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    npc_en = 0; off_en = 0; alu_mc = 0; csr_mc = 0;
  endtask

  function automatic logic [15:0] csr(logic [11:0] a, logic [2:0] o);
    return {1'b1, a, o};
  endfunction

  // monitor: results of an edge are compared 1 time unit after it
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      compare(e.name, pick(e.sel), e.val);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got %0d want 0 pending", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    compare("rst_npc", next_pc, 0);
    compare("rst_alu", alu_out, 0);
    compare("rst_csr", csr_out, 0);
    compare("rst_fault", {31'b0, fault}, 0);
    @(negedge clk); @(negedge clk);
    reset = 1;
    step(); npc_en = 1; off_en = 1; pc = 32'hFFFF_FFFC; imm = 8;
    expect_out(0, 0, "npc_wrap"); expect_out(1, 4, "off_wrap");
    step(); pc = 32'h100;
    expect_out(0, 0, "npc_hold"); expect_out(1, 4, "off_hold");
    step(); alu_mc = {1'b1, ALU_SRA}; alu_a = 32'h8000_0000; alu_b = 4;
    expect_out(2, 32'hF800_0000, "sra"); expect_out(5, 32'hF800_0000, "ex_alu");
    step(); alu_mc = {1'b1, ALU_SRL};
    expect_out(2, 32'h0800_0000, "srl");
    step(); alu_mc = {1'b1, ALU_SUB}; alu_a = 5; alu_b = 7;
    expect_out(2, 32'hFFFF_FFFE, "sub");
    step(); alu_mc = 6'b101001;
    expect_out(4, 1, "alu_fault"); expect_out(2, 32'hFFFF_FFFE, "alu_hold");
    step(); alu_mc = {1'b1, ALU_ADD};
    expect_out(4, 0, "alu_fault_clr"); expect_out(2, 12, "add");
    step(); alu_mc = {1'b1, ALU_BLT}; alu_a = 32'hFFFF_FFFF; alu_b = 1;
    expect_out(2, 1, "blt");
    step(); alu_mc = {1'b1, ALU_BLTU};
    expect_out(2, 0, "bltu");
    step(); alu_mc = {1'b1, ALU_BNE};
    expect_out(2, 1, "bne");
    step(); alu_mc = {1'b1, ALU_BEQ};
    expect_out(2, 0, "beq");
    step(); csr_mc = csr(ADDR_MTVEC, CSR_RW); csr_in = 32'h8000_0103;
    expect_out(3, 0, "mtvec_rw_old");
    step(); csr_mc = csr(ADDR_MTVEC, CSR_RS); csr_in = 0;
    expect_out(3, 32'h8000_0100, "mtvec_rd"); expect_out(5, 32'h8000_0100, "ex_csr");
    step(); csr_mc = csr(ADDR_MTVEC, CSR_RC); csr_in = 32'h8000_0000;
    expect_out(3, 32'h8000_0100, "mtvec_rc_old");
    step(); csr_mc = csr(ADDR_MTVEC, CSR_RS); csr_in = 0;
    expect_out(3, 32'h0000_0100, "mtvec_rc_new");
    step(); csr_mc = csr(ADDR_MISA, CSR_RW); csr_in = 5;
    expect_out(4, 1, "misa_wr_fault"); expect_out(3, 32'h0000_0100, "csr_hold");
    step(); csr_mc = csr(ADDR_MISA, CSR_RS); csr_in = 0;
    expect_out(4, 0, "misa_rd_ok"); expect_out(3, MISA_VAL, "misa");
    step(); csr_mc = csr(ADDR_MTVEC, CSR_RW); csr_in = 32'h200;
    expect_out(3, 32'h0000_0100, "mtvec_rw2");
    step(); csr_mc = csr(12'hABC, CSR_ECALL); csr_in = 32'h1000;
    expect_out(3, 32'h200, "ecall");
    step(); csr_mc = csr(ADDR_MCAUSE, CSR_RS); csr_in = 0;
    expect_out(3, 11, "mcause");
    step(); csr_mc = csr(0, CSR_MRET);
    expect_out(3, 32'h1000, "mret");
    step(); csr_mc = csr(ADDR_MEPC, 3'b111);
    expect_out(4, 1, "csr_bad_op"); expect_out(3, 32'h1000, "csr_bad_hold");
    step(); csr_mc = csr(ADDR_MSCRATCH, CSR_RW); csr_in = 32'hDEAD_BEEF;
    expect_out(4, 0, "csr_clr");
    step(); csr_mc = csr(ADDR_MSCRATCH, CSR_RS); csr_in = 0;
    expect_out(3, 32'hDEAD_BEEF, "mscratch");
    step(); csr_mc = csr(12'h123, CSR_RS);
    expect_out(4, 1, "undef_addr");
    step(); npc_en = 1; off_en = 1; pc = 32'h10; imm = 8;
    alu_mc = 6'b111000; csr_mc = csr(ADDR_MHARTID, CSR_RS);
    expect_out(0, 32'h14, "npc_pre"); expect_out(1, 32'h18, "off_pre");
    expect_out(3, 0, "mhartid"); expect_out(4, 1, "fault_pre");
    @(posedge clk); #3;
    reset = 0; #1;
    compare("arst_npc", next_pc, 0);
    compare("arst_off", offset_pc, 0);
    compare("arst_alu", alu_out, 0);
    compare("arst_csr", csr_out, 0);
    compare("arst_fault", {31'b0, fault}, 0);
    step(); reset = 1; npc_en = 1; pc = 32'h20; csr_mc = csr(ADDR_MSCRATCH, CSR_RS); csr_in = 0;
    expect_out(0, 32'h24, "npc_post"); expect_out(3, 0, "mscratch_cleared");
    step(); step();
    compare("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
